// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the data-SRAM port arbiter.
// FSM state encoding, requester IDs and bus widths.
package sram_arb_pkg;

    localparam int ARB_ADDR_W = 11;
    localparam int ARB_DATA_W = 32;

    localparam logic ARB_CPU = 1'b0;
    localparam logic ARB_LDR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_arb_select.sv
// Winner selection for the SRAM port arbiter.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of CPU priority.
module sram_arb_select
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic cpu_req,
    input  logic ldr_req,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    input  logic take,
`else
    input  logic ldr_gnt,
`endif
    output logic winner
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN

    logic last;

    // Remember who won the most recent arbitration; loader after reset.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            last <= ARB_LDR;
        end else if (take) begin
            last <= winner;
        end
    end

    // A tie goes to whoever did not win last time.
    always_comb begin
        winner = ARB_CPU;
        if (cpu_req && ldr_req) begin
            winner = ~last;
        end else if (ldr_req) begin
            winner = ARB_LDR;
        end
    end

`else

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve;

    // Count cycles the loader waits ungranted, saturating at 255.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            starve <= 8'd0;
        end else if (!ldr_req || ldr_gnt) begin
            starve <= 8'd0;
        end else if (starve != 8'hFF) begin
            starve <= starve + 8'd1;
        end
    end

    // CPU has priority unless the loader has waited long enough.
    always_comb begin
        winner = ARB_CPU;
        if (ldr_req && (!cpu_req || starve >= LIMIT)) begin
            winner = ARB_LDR;
        end
    end

`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the data-SRAM port between CPU and loader.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN enables round-robin selection.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [10:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    input  logic        ldr_req,
    input  logic        ldr_rnw,
    input  logic [10:0] ldr_addr,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_gnt,
    output logic        ldr_done,
    output logic [31:0] ldr_rdata,
    output logic [10:0] sram_adx,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_oe,
    output logic        sram_rnw
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    arb_state_t state;
    arb_state_t state_next;

    logic [3:0]            cnt;
    logic                  owner;
    logic                  acc_rnw;
    logic [ARB_ADDR_W-1:0] acc_addr;
    logic [ARB_DATA_W-1:0] acc_wdata;

    logic                  winner;
    logic                  take;
    logic                  finish;
    logic                  in_access;
    logic                  win_rnw;
    logic [ARB_ADDR_W-1:0] win_addr;
    logic [ARB_DATA_W-1:0] win_wdata;

    assign take      = (state == ST_IDLE) && (cpu_req || ldr_req);
    assign in_access = (state == ST_ACCESS);
    assign finish    = in_access && (cnt == 4'd0);

    assign win_rnw   = (winner == ARB_LDR) ? ldr_rnw   : cpu_rnw;
    assign win_addr  = (winner == ARB_LDR) ? ldr_addr  : cpu_addr;
    assign win_wdata = (winner == ARB_LDR) ? ldr_wdata : cpu_wdata;

    sram_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_sel (
        .clk    (clk),
        .Reset  (Reset),
        .cpu_req(cpu_req),
        .ldr_req(ldr_req),
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        .take   (take),
`else
        .ldr_gnt(ldr_gnt),
`endif
        .winner (winner)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one access window, then a turnaround cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:     if (cpu_req || ldr_req) state_next = ST_ACCESS;
            ST_ACCESS:   if (cnt == 4'd0) state_next = ST_COMPLETE;
            ST_COMPLETE: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Latch the winning request and run the access window counter.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            cnt       <= 4'd0;
            owner     <= ARB_CPU;
            acc_rnw   <= 1'b1;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else if (take) begin
            cnt      <= CNT_LOAD;
            owner    <= winner;
            acc_rnw  <= win_rnw;
            acc_addr <= win_addr;
            if (!win_rnw) begin
                acc_wdata <= win_wdata;
            end
        end else if (in_access && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Grant and done pulses plus read data capture for the owner.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            cpu_gnt   <= 1'b0;
            ldr_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            ldr_done  <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            cpu_gnt  <= take && (winner == ARB_CPU);
            ldr_gnt  <= take && (winner == ARB_LDR);
            cpu_done <= finish && (owner == ARB_CPU);
            ldr_done <= finish && (owner == ARB_LDR);
            if (finish && acc_rnw) begin
                if (owner == ARB_CPU) begin
                    cpu_rdata <= sram_rdata;
                end else begin
                    ldr_rdata <= sram_rdata;
                end
            end
        end
    end

    assign sram_adx   = acc_addr;
    assign sram_wdata = acc_wdata;
    assign sram_oe    = in_access && acc_rnw;
    assign sram_rnw   = !in_access || acc_rnw;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter.
// Transaction table, corner sequences and random traffic vs a model.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AC = 2;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_rnw, ldr_req, ldr_rnw;
    logic [10:0] cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_gnt, cpu_done, ldr_gnt, ldr_done;
    logic [31:0] cpu_rdata, ldr_rdata;
    logic [10:0] sram_adx;
    logic [31:0] sram_wdata, sram_rdata;
    logic        sram_oe, sram_rnw;

    logic [31:0] mem [0:2047];
    assign sram_rdata = mem[sram_adx];

    always #5 clk = ~clk;

    sram_port_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_rnw(ldr_rnw), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_done(ldr_done),
        .ldr_rdata(ldr_rdata),
        .sram_adx(sram_adx), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_oe(sram_oe), .sram_rnw(sram_rnw)
    );

    // Reference model: phase 0 idle, 1..AC access, AC+1 complete.
    int          m_phase;
    logic        m_owner, m_rnw, m_last;
    logic [10:0] m_addr;
    logic [31:0] m_wd;
    int          m_starve;
    logic        e_cg, e_lg, e_cd, e_ld;
    logic [31:0] e_cr, e_lr;
    logic [31:0] ref_mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        who;
        logic        rnw;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_cr;
        logic [31:0] exp_lr;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic model_winner();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (cpu_req && ldr_req) return ~m_last;
        return ldr_req;
`else
        return ldr_req && (!cpu_req || m_starve >= SL);
`endif
    endfunction

    task automatic model_step();
        logic w;
        int   ns;
        if (!Reset) begin
            m_phase = 0; m_starve = 0; m_last = 1'b1; m_rnw = 1'b1;
            m_addr = '0; m_wd = '0; m_owner = 1'b0;
            e_cg = 0; e_lg = 0; e_cd = 0; e_ld = 0;
            e_cr = '0; e_lr = '0;
        end else begin
            w  = model_winner();
            ns = (ldr_req && !e_lg) ? ((m_starve < 255) ? m_starve + 1 : 255) : 0;
            e_cg = 0; e_lg = 0; e_cd = 0; e_ld = 0;
            if (m_phase == 0) begin
                if (cpu_req || ldr_req) begin
                    m_phase = 1;
                    m_owner = w;
                    m_last  = w;
                    if (w) e_lg = 1; else e_cg = 1;
                    m_rnw  = w ? ldr_rnw : cpu_rnw;
                    m_addr = w ? ldr_addr : cpu_addr;
                    if (!m_rnw) begin
                        m_wd = w ? ldr_wdata : cpu_wdata;
                        ref_mem[m_addr] = m_wd;
                    end
                end
            end else if (m_phase < AC) begin
                m_phase++;
            end else if (m_phase == AC) begin
                m_phase = AC + 1;
                if (m_owner) e_ld = 1; else e_cd = 1;
                if (m_rnw) begin
                    if (m_owner) e_lr = ref_mem[m_addr];
                    else e_cr = ref_mem[m_addr];
                end
            end else begin
                m_phase = 0;
            end
            m_starve = ns;
        end
    endtask

    task automatic check_outputs();
        logic acc;
        acc = (m_phase >= 1) && (m_phase <= AC);
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
        chk("ldr_gnt", 32'(ldr_gnt), 32'(e_lg));
        chk("cpu_done", 32'(cpu_done), 32'(e_cd));
        chk("ldr_done", 32'(ldr_done), 32'(e_ld));
        chk("cpu_rdata", cpu_rdata, e_cr);
        chk("ldr_rdata", ldr_rdata, e_lr);
        chk("sram_oe", 32'(sram_oe), 32'(acc && m_rnw));
        chk("sram_rnw", 32'(sram_rnw), 32'(!acc || m_rnw));
        chk("sram_adx", 32'(sram_adx), 32'(m_addr));
        chk("sram_wdata", sram_wdata, m_wd);
        chk("one_gnt", 32'(cpu_gnt && ldr_gnt), 32'd0);
    endtask

    task automatic tick();
        model_step();
        if (sram_rnw === 1'b0) mem[sram_adx] = sram_wdata;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_txn(input vec_t v);
        int gl, dl, wr;
        gl = -1; dl = -1; wr = 0;
        if (!v.who) begin
            cpu_req = 1'b1; cpu_rnw = v.rnw;
            cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            ldr_req = 1'b1; ldr_rnw = v.rnw;
            ldr_addr = v.addr; ldr_wdata = v.wdata;
        end
        for (int i = 1; i <= 20 && dl < 0; i++) begin
            tick();
            if (sram_rnw === 1'b0) wr++;
            if ((v.who ? ldr_gnt : cpu_gnt) === 1'b1 && gl < 0) begin
                gl = i;
                cpu_req = 1'b0;
                ldr_req = 1'b0;
            end
            if ((v.who ? ldr_done : cpu_done) === 1'b1) dl = i;
        end
        chk("txn_gnt_lat", 32'(gl), 32'd1);
        chk("txn_done_lat", 32'(dl), 32'(AC + 1));
        chk("txn_wr_cycles", 32'(wr), v.rnw ? 32'd0 : 32'(AC));
        chk("txn_cpu_rdata", cpu_rdata, v.exp_cr);
        chk("txn_ldr_rdata", ldr_rdata, v.exp_lr);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   order [4];
        int   ng, cg;
        logic got;

        for (int i = 0; i < 2048; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        Reset = 1'b0;
        cpu_req = 0; cpu_rnw = 1; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_rnw = 1; ldr_addr = '0; ldr_wdata = '0;

        tbl[0] = '{1'b0, 1'b0, 11'h005, 32'hDEADBEEF, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 11'h005, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 11'h7FF, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 11'h7FF, 32'h0, 32'hDEADBEEF, 32'h12345678};
        tbl[4] = '{1'b0, 1'b0, 11'h000, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h12345678};
        tbl[5] = '{1'b1, 1'b1, 11'h000, 32'h0, 32'hDEADBEEF, 32'hA5A5A5A5};
        tbl[6] = '{1'b0, 1'b1, 11'h7FF, 32'h0, 32'h12345678, 32'hA5A5A5A5};

        tick();
        tick();
        chk("reset_state", 32'(u_dut.state), 32'(ST_IDLE));
        chk("reset_adx", 32'(sram_adx), 32'd0);
        Reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) do_txn(tbl[i]);

        // Simultaneous requests: CPU first, loader next, never together.
        cpu_req = 1; cpu_rnw = 0; cpu_addr = 11'h010; cpu_wdata = 32'h1111;
        ldr_req = 1; ldr_rnw = 0; ldr_addr = 11'h011; ldr_wdata = 32'h2222;
        ng = 0;
        for (int i = 0; i < 30 && ng < 2; i++) begin
            tick();
            if (cpu_gnt === 1'b1) begin order[ng] = 0; ng++; cpu_req = 0; end
            if (ldr_gnt === 1'b1) begin order[ng] = 1; ng++; ldr_req = 0; end
        end
        chk("tie_gnts", 32'(ng), 32'd2);
        chk("tie_first", 32'(order[0]), 32'd0);
        chk("tie_second", 32'(order[1]), 32'd1);
        idle(AC + 3);

        // Continuous CPU traffic must not starve a waiting loader.
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 11'h005;
        ldr_req = 1; ldr_rnw = 1; ldr_addr = 11'h7FF;
        cg = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (cpu_gnt === 1'b1) cg++;
            if (ldr_gnt === 1'b1) begin got = 1; ldr_req = 0; end
        end
        chk("starve_ldr_gnt", 32'(got), 32'd1);
        chk("starve_cpu_before", 32'(cg), 32'd1);
        tick();
`ifndef SRAM_ARB_ROUND_ROBIN_EN
        chk("starve_clear", 32'(u_dut.u_sel.starve), 32'd0);
`endif
        idle(AC + 3);

        // Reset in the second access cycle of a loader read.
        ldr_req = 1; ldr_rnw = 1; ldr_addr = 11'h7FF;
        tick();
        chk("abort_gnt", 32'(ldr_gnt), 32'd1);
        ldr_req = 0;
        tick();
        Reset = 1'b0;
        tick();
        chk("abort_done", 32'(ldr_done), 32'd0);
        chk("abort_oe", 32'(sram_oe), 32'd0);
        chk("abort_rnw", 32'(sram_rnw), 32'd1);
        chk("abort_rdata", ldr_rdata, 32'd0);
        chk("abort_state", 32'(u_dut.state), 32'(ST_IDLE));
        Reset = 1'b1;
        tick();

        // Both requests held: grants alternate.
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 11'h000;
        ldr_req = 1; ldr_rnw = 1; ldr_addr = 11'h005;
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            tick();
            if (cpu_gnt === 1'b1) begin order[ng] = 0; ng++; end
            if (ldr_gnt === 1'b1 && ng < 4) begin order[ng] = 1; ng++; end
        end
        chk("alt_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) chk("alt_order", 32'(order[i]), 32'(i % 2));
        idle(AC + 3);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            int a;
            Reset   = ($urandom_range(0, 299) != 0);
            cpu_req = ($urandom_range(0, 2) == 0);
            ldr_req = ($urandom_range(0, 2) == 0);
            cpu_rnw = $urandom_range(0, 1) == 1;
            ldr_rnw = $urandom_range(0, 1) == 1;
            a = $urandom_range(0, 8);
            cpu_addr = (a == 8) ? 11'h7FF : 11'(a);
            a = $urandom_range(0, 8);
            ldr_addr = (a == 8) ? 11'h7FF : 11'(a);
            cpu_wdata = $urandom;
            ldr_wdata = $urandom;
            tick();
        end
        Reset = 1'b1;
        idle(AC + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
